param_seq_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 31 +++
 rtl/mult_digit_pp.sv | 14 +
 rtl/param_seq_multiplier.sv | 108 ++++++++++
 tb/tb_param_seq_multiplier.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and width helpers for the digit-serial multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Full product width: never overflows for any operand pair.
  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  // Number of multiplier digits processed per operation at most.
  function automatic int unsigned num_digits(input int unsigned m_w, input int unsigned d_w);
    return m_w / d_w;
  endfunction

  // Digit counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Two's-complement negate when en is set; callers truncate to their width,
  // which makes the most-negative value map onto its own unsigned magnitude.
  function automatic logic [63:0] cond_negate(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Unsigned multiplicand x one multiplier digit partial product.
module mult_digit_pp #(
  parameter int unsigned MCAND_W = 4,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [MCAND_W-1:0]         a,
  input  logic [DIGIT_W-1:0]         d,
  output logic [MCAND_W+DIGIT_W-1:0] pp
);

  // Both operands zero-extended to the result width before multiplying.
  always_comb pp = {{DIGIT_W{1'b0}}, a} * {{MCAND_W{1'b0}}, d};

endmodule

// File: rtl/param_seq_multiplier.sv
// Digit-serial signed/unsigned multiplier with start/done/busy handshake and
// early termination once the remaining multiplier digits are all zero.
module param_seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned MCAND_W = 4,
  parameter int unsigned MULT_W  = 16,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st,
  input  logic                      sgn,
  input  logic [MCAND_W-1:0]        mcand,
  input  logic [MULT_W-1:0]         mult,
  output logic [MCAND_W+MULT_W-1:0] product,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned P_W   = prod_width(MCAND_W, MULT_W);
  localparam int unsigned N     = num_digits(MULT_W, DIGIT_W);
  localparam int unsigned CNT_W = cnt_width(N);

  if ((MULT_W % DIGIT_W) != 0) begin : g_bad_digit
    $error("DIGIT_W must divide MULT_W");
  end
  if (MCAND_W < 2 || MULT_W < 2 || P_W > 64) begin : g_bad_width
    $error("operand widths must be >= 2 and product width <= 64");
  end

  state_t                   state, state_nxt;
  logic [MCAND_W-1:0]       mag_a;
  logic [MULT_W-1:0]        mreg, mreg_shift;
  logic [P_W-1:0]           acc, acc_add;
  logic [CNT_W-1:0]         cnt;
  logic                     neg;
  logic                     last_digit;
  logic [MCAND_W+DIGIT_W-1:0] pp;

  mult_digit_pp #(
    .MCAND_W(MCAND_W),
    .DIGIT_W(DIGIT_W)
  ) u_pp (
    .a (mag_a),
    .d (mreg[DIGIT_W-1:0]),
    .pp(pp)
  );

  // Accumulate the weighted partial product and look ahead at the shifted multiplier.
  always_comb begin
    mreg_shift = mreg >> DIGIT_W;
    acc_add    = acc + (P_W'(pp) << (cnt * DIGIT_W));
    last_digit = (mreg_shift == '0) || (cnt == CNT_W'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (st) state_nxt = CALC;
      CALC:    if (last_digit) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy covers every non-idle cycle, so it never overlaps the done pulse.
  always_comb busy = (state != IDLE);

  // Operand capture, digit accumulation, sign fix-up and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a   <= '0;
      mreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: if (st) begin
          mag_a <= MCAND_W'(cond_negate(64'(mcand), sgn & mcand[MCAND_W-1]));
          mreg  <= MULT_W'(cond_negate(64'(mult), sgn & mult[MULT_W-1]));
          neg   <= sgn & (mcand[MCAND_W-1] ^ mult[MULT_W-1]);
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          acc  <= acc_add;
          mreg <= mreg_shift;
          cnt  <= cnt + CNT_W'(1);
        end
        FIX:  product <= P_W'(cond_negate(64'(acc), neg));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Scoreboard bench: default instance plus three parameter variants.
module tb_param_seq_multiplier;

  localparam int AW [4] = '{4, 8, 8, 4};
  localparam int BW [4] = '{16, 8, 8, 16};
  localparam int DW [4] = '{4, 1, 2, 16};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  st_v = '0;
  logic [3:0]  sgn_v = '0;
  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  logic        d0, d1, d2, d3, bz0, bz1, bz2, bz3;
  logic [19:0] p0, p3;
  logic [15:0] p1, p2;

  typedef struct {
    int          inst;
    logic [63:0] prod;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_seq_multiplier u_dut0 (
    .clk(clk), .rst(rst), .st(st_v[0]), .sgn(sgn_v[0]), .mcand(a_v[0][3:0]),
    .mult(b_v[0]), .product(p0), .busy(bz0), .done(d0));
  param_seq_multiplier #(.MCAND_W(8), .MULT_W(8), .DIGIT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .st(st_v[1]), .sgn(sgn_v[1]), .mcand(a_v[1][7:0]),
    .mult(b_v[1][7:0]), .product(p1), .busy(bz1), .done(d1));
  param_seq_multiplier #(.MCAND_W(8), .MULT_W(8), .DIGIT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .st(st_v[2]), .sgn(sgn_v[2]), .mcand(a_v[2][7:0]),
    .mult(b_v[2][7:0]), .product(p2), .busy(bz2), .done(d2));
  param_seq_multiplier #(.MCAND_W(4), .MULT_W(16), .DIGIT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .st(st_v[3]), .sgn(sgn_v[3]), .mcand(a_v[3][3:0]),
    .mult(b_v[3]), .product(p3), .busy(bz3), .done(d3));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0: return bz0;
      1: return bz1;
      2: return bz2;
      default: return bz3;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int i);
    case (i)
      0: return 64'(p0);
      1: return 64'(p1);
      2: return 64'(p2);
      default: return 64'(p3);
    endcase
  endfunction

  // Reference: exact integer product and the number of digits actually needed.
  function automatic void model(input int i, input bit s, input logic [15:0] a,
                                input logic [15:0] b, output logic [63:0] p, output int lat);
    int aw = AW[i];
    int bw = BW[i];
    int dw = DW[i];
    int n, k;
    longint am, bm, va, vb, mb;
    am = longint'(a) & ((longint'(1) << aw) - 1);
    bm = longint'(b) & ((longint'(1) << bw) - 1);
    va = (s && am[aw-1]) ? am - (longint'(1) << aw) : am;
    vb = (s && bm[bw-1]) ? bm - (longint'(1) << bw) : bm;
    p  = 64'(va * vb) & ((64'd1 << (aw + bw)) - 64'd1);
    mb = (vb < 0) ? -vb : vb;
    n  = bw / dw;
    k  = 1;
    while (k < n && (mb >> (k * dw)) != 0) k++;
    lat = k + 1;
  endfunction

  // Compare every completion against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (get_done(i)) begin
          check_eq($sformatf("done_busy_overlap[%0d]", i), 64'(get_busy(i)), 64'd0);
          if (sb.size() == 0) begin
            check_eq($sformatf("spurious_done[%0d]", i), 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check_eq($sformatf("inst[%0d]", i), 64'(i), 64'(e.inst));
            check_eq($sformatf("product[%0d]", i), get_prod(i), e.prod);
            check_eq($sformatf("latency[%0d]", i), 64'(cyc - e.start), 64'(e.lat));
            check_eq($sformatf("busy_cycles[%0d]", i), 64'(busy_cnt[i]), 64'(e.lat));
          end
          busy_cnt[i] = 0;
        end else if (get_busy(i)) begin
          busy_cnt[i] = busy_cnt[i] + 1;
        end
      end
    end
  end

  task automatic start_op(input int i, input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [63:0] p;
    int          l;
    model(i, s, a, b, p, l);
    @(negedge clk);
    st_v[i] = 1'b1; sgn_v[i] = s; a_v[i] = a; b_v[i] = b;
    e = '{i, p, l, cyc + 1};
    sb.push_back(e);
    @(negedge clk);
    st_v[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t        e;
    logic [63:0] p;
    int          l, s0, target;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    #1 rst = 1'b1;
    #2;
    check_eq("rst_product0", get_prod(0), 64'd0);
    check_eq("rst_busy0", 64'(bz0), 64'd0);
    check_eq("rst_done0", 64'(d0), 64'd0);
    check_eq("rst_product3", get_prod(3), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases on the default instance.
    start_op(0, 1'b0, 16'd3, 16'd1000);       wait_idle();
    start_op(0, 1'b0, 16'd15, 16'd0);         wait_idle();
    start_op(0, 1'b0, 16'd15, 16'hFFFF);      wait_idle();
    start_op(0, 1'b1, 16'h8, 16'h8000);       wait_idle();
    start_op(0, 1'b1, 16'd7, 16'hFFFF);       wait_idle();
    start_op(0, 1'b1, 16'h8, 16'd0);          wait_idle();
    start_op(0, 1'b1, 16'd0, 16'h8000);       wait_idle();

    // st pulsed throughout the busy window with changing operands.
    start_op(0, 1'b0, 16'd15, 16'hFFFF);
    for (int k = 0; k < 5; k++) begin
      st_v[0] = 1'b1; sgn_v[0] = 1'($urandom);
      a_v[0] = 16'($urandom); b_v[0] = 16'($urandom);
      @(negedge clk);
    end
    st_v[0] = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);

    // st held high: three back-to-back operations.
    model(0, 1'b0, 16'd3, 16'd1000, p, l);
    @(negedge clk);
    st_v[0] = 1'b1; sgn_v[0] = 1'b0; a_v[0] = 16'd3; b_v[0] = 16'd1000;
    s0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e = '{0, p, l, s0 + k * (l + 1)};
      sb.push_back(e);
    end
    target = s0 + 2 * (l + 1);
    for (int k = 0; k < 40 && cyc < target; k++) @(negedge clk);
    st_v[0] = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    start_op(0, 1'b0, 16'd15, 16'hFFFF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(bz0), 64'd0);
    check_eq("midrst_done", 64'(d0), 64'd0);
    check_eq("midrst_product", get_prod(0), 64'd0);
    sb.delete();
    for (int i = 0; i < 4; i++) busy_cnt[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    start_op(0, 1'b0, 16'd2, 16'd2);          wait_idle();

    // Parameter variants: corners then random operands.
    for (int i = 1; i < 4; i++) begin
      start_op(i, 1'b1, 16'h8080, 16'h8000);  wait_idle();
      start_op(i, 1'b0, 16'hFFFF, 16'hFFFF);  wait_idle();
      for (int k = 0; k < 8; k++) begin
        start_op(i, 1'($urandom), 16'($urandom), 16'($urandom));
        wait_idle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
